// File: rtl/neuron_mac_stream.sv
// Streaming multiply-accumulate for one neuron pre-activation z = bias + sum(x*w).
// Full-precision accumulator; the result is rounded and saturated to Q6.9, then held on a valid/ready output.
module neuron_mac_stream #(
    parameter int VEC_LEN = 8,
    parameter int DATA_W  = 16,
    parameter int FRAC    = 9,
    parameter int ACC_W   = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_w,
    input  logic [DATA_W-1:0] in_bias,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_z,
    output logic              busy
);

    // state | meaning
    // IDLE  | waiting for the first pair; bias is loaded with it
    // ACC   | accumulating pairs 2..VEC_LEN
    // FIN   | one cycle: round, saturate, register out_z
    // OUT   | holding out_z until the downstream consumes it
    typedef enum logic [1:0] {IDLE, ACC, FIN, OUT} state_t;

    localparam int CNT_W = 8;
    localparam int HB    = ACC_W - DATA_W + 1;
    localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC - 1);

    state_t state, state_nxt;
    logic [CNT_W-1:0] count;
    logic signed [ACC_W-1:0] acc;
    logic signed [2*DATA_W-1:0] x_ext, w_ext, prod;
    logic signed [ACC_W-1:0] prod_ext, bias_ext, rnd, shr;
    logic [DATA_W-1:0] z_sat;
    logic accept, consume;

    assign in_ready  = (state == IDLE) || (state == ACC);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    assign x_ext    = {{DATA_W{in_x[DATA_W-1]}}, in_x};
    assign w_ext    = {{DATA_W{in_w[DATA_W-1]}}, in_w};
    assign prod     = x_ext * w_ext;
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-DATA_W-FRAC){in_bias[DATA_W-1]}}, in_bias, {FRAC{1'b0}}};

    // Round half toward +inf, then clamp anything outside the 16-bit signed range.
    assign rnd = acc + HALF;
    assign shr = rnd >>> FRAC;

    always_comb begin
        z_sat = shr[DATA_W-1:0];
        if ((shr[ACC_W-1:DATA_W-1] != {HB{1'b0}}) && (shr[ACC_W-1:DATA_W-1] != {HB{1'b1}})) begin
            if (shr[ACC_W-1])
                z_sat = {1'b1, {(DATA_W-1){1'b0}}};
            else
                z_sat = {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (VEC_LEN == 1) ? FIN : ACC;
            ACC:  if (accept && (count == CNT_W'(VEC_LEN - 1))) state_nxt = FIN;
            FIN:  state_nxt = OUT;
            OUT:  if (consume) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            acc   <= '0;
            out_z <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    acc   <= prod_ext + bias_ext;
                    count <= CNT_W'(1);
                end
                ACC: if (accept) begin
                    acc   <= acc + prod_ext;
                    count <= count + 1'b1;
                end
                FIN: out_z <= z_sat;
                OUT: if (consume) begin
                    acc   <= '0;
                    count <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_stream.sv
// Directed bench for neuron_mac_stream: latency, rounding, saturation, backpressure, bubbles, reset.
module tb_neuron_mac_stream;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_w;
    logic [15:0] in_bias;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_z;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [15:0] vx [8];
    logic [15:0] vw [8];

    neuron_mac_stream dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_w(in_w), .in_bias(in_bias),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [15:0] x, input logic [15:0] w);
        for (int i = 0; i < 8; i++) begin
            vx[i] = x;
            vw[i] = w;
        end
    endtask

    // Presents one pair and returns 1ns after the edge that accepts it.
    task automatic send_pair(input logic [15:0] x, input logic [15:0] w, input logic [15:0] b,
                             output bit ok);
        int n;
        bit rdy;
        in_valid = 1'b1;
        in_x = x;
        in_w = w;
        in_bias = b;
        n = 0;
        do begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 100);
        ok = rdy;
    endtask

    task automatic send_vec(input logic [15:0] bias, input int gap_max);
        bit ok;
        bit all_ok;
        all_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                in_valid = 1'b0;
                in_x = 16'($urandom);
                in_w = 16'($urandom);
                in_bias = 16'($urandom);
                @(posedge clk);
                #1;
            end
            send_pair(vx[i], vw[i], (i == 0) ? bias : 16'($urandom), ok);
            all_ok = all_ok & ok;
        end
        in_valid = 1'b0;
        if (!all_ok) chk("accept_timeout", 40'(all_ok), 40'd1);
    endtask

    task automatic get_result(output logic [15:0] z, output bit got);
        int n;
        n = 0;
        got = 1'b0;
        z = 16'hxxxx;
        while (!got && n < 100) begin
            if (out_valid) begin
                got = 1'b1;
                z = out_z;
            end else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] bias);
        longint s;
        longint r;
        longint m;
        s = longint'($signed(bias)) * 512;
        for (int i = 0; i < 8; i++)
            s += longint'($signed(vx[i])) * longint'($signed(vw[i]));
        s = s + 256;
        m = ((s % 512) + 512) % 512;
        r = (s - m) / 512;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    task automatic run_one(input string tag, input logic [15:0] bias, input logic [15:0] exp);
        logic [15:0] z;
        bit got;
        send_vec(bias, 0);
        get_result(z, got);
        chk({tag, "_got"}, 40'(got), 40'd1);
        chk(tag, 40'(z), 40'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] z;
        logic [15:0] b;
        logic [15:0] exp_z;
        bit got;
        bit ok;

        rst = 1'b1;
        in_valid = 1'b0;
        in_x = '0;
        in_w = '0;
        in_bias = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 40'(out_valid), 40'd0);
        chk("rst_out_z", 40'(out_z), 40'd0);
        chk("rst_in_ready", 40'(in_ready), 40'd1);
        chk("rst_busy", 40'(busy), 40'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Unity sum with exact latency: valid rises one edge after the last accept, lasts one cycle.
        fill(16'h0200, 16'h0200);
        send_vec(16'h0000, 0);
        chk("unity_fin_busy", 40'(busy), 40'd1);
        chk("unity_fin_no_valid", 40'(out_valid), 40'd0);
        chk("unity_fin_in_ready", 40'(in_ready), 40'd0);
        @(posedge clk);
        #1;
        chk("unity_valid_rise", 40'(out_valid), 40'd1);
        chk("unity_z", 40'(out_z), 40'h1000);
        @(posedge clk);
        #1;
        chk("unity_valid_fall", 40'(out_valid), 40'd0);
        chk("unity_idle_busy", 40'(busy), 40'd0);

        fill(16'h0000, 16'h0200);
        vx[0] = 16'h0001;
        vw[0] = 16'h0100;
        run_one("bias_round_pos", 16'h0100, 16'h0101);
        vx[0] = 16'hFFFF;
        run_one("bias_round_half", 16'h0100, 16'h0100);

        fill(16'h7FFF, 16'h7FFF);
        run_one("sat_pos", 16'h0000, 16'h7FFF);
        fill(16'h7FFF, 16'h8000);
        run_one("sat_neg", 16'h0000, 16'h8000);

        // Backpressure: unity result held while the next vector's first pair waits.
        out_ready = 1'b0;
        fill(16'h0200, 16'h0200);
        send_vec(16'h0000, 0);
        in_valid = 1'b1;
        in_x = 16'h0400;
        in_w = 16'h0200;
        in_bias = 16'h0000;
        chk("bp_fin_in_ready", 40'(in_ready), 40'd0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 40'(out_valid), 40'd1);
            chk("bp_z", 40'(out_z), 40'h1000);
            chk("bp_in_ready", 40'(in_ready), 40'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_consumed", 40'(out_valid), 40'd0);
        chk("bp_idle_ready", 40'(in_ready), 40'd1);
        fill(16'h0400, 16'h0200);
        run_one("bp_second", 16'h0000, 16'h2000);

        // Bubbles with random data against the reference model.
        for (int v = 0; v < 200; v++) begin
            for (int i = 0; i < 8; i++) begin
                vx[i] = 16'($urandom);
                vw[i] = 16'($urandom);
                if (v % 2 == 0) begin
                    vx[i] = {{6{vx[i][9]}}, vx[i][9:0]};
                    vw[i] = {{6{vw[i][9]}}, vw[i][9:0]};
                end
            end
            b = 16'($urandom);
            exp_z = model(b);
            send_vec(b, 3);
            get_result(z, got);
            chk("rand_z", 40'(z), 40'(exp_z));
        end
        @(posedge clk);
        #1;

        // Reset mid-vector discards partial data.
        fill(16'h0200, 16'h0200);
        for (int i = 0; i < 4; i++) send_pair(16'h0200, 16'h0200, 16'h0000, ok);
        chk("mid_accepts", 40'(ok), 40'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("mid_rst_valid", 40'(out_valid), 40'd0);
        chk("mid_rst_busy", 40'(busy), 40'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_valid2", 40'(out_valid), 40'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_busy", 40'(busy), 40'd0);
        chk("post_rst_ready", 40'(in_ready), 40'd1);
        @(posedge clk);
        #1;
        run_one("post_rst_unity", 16'h0000, 16'h1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neuron_mac_stream.md
Name: neuron_mac_stream

Overview:
- Upstream feeder for the sigmoid PWL activation stage: computes one neuron pre-activation z = bias + sum(x[i]*w[i]), i = 0..VEC_LEN-1.
- Operands, bias and result are all signed Q6.9: 16 bit, 9 fractional bits, 0x0200 = 1.0.
- Operand pairs arrive over a valid/ready stream.
- The accumulator runs at full precision. The result is rounded and saturated to 16 bit, then held on a valid/ready output whose data drives the sigmoid x input.

Parameters:
- VEC_LEN, 8, number of (x,w) pairs per neuron; legal range 1..255.
- DATA_W, 16, operand/bias/result width.
- FRAC, 9, fractional bits of every Q-format operand.
- ACC_W, 40, accumulator width; must be >= 2*DATA_W + ceil(log2(VEC_LEN+1)).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, an operand pair and bias are presented.
- in_ready, output, 1, the block accepts a pair this cycle.
- in_x, input, DATA_W, signed activation operand, Q6.9.
- in_w, input, DATA_W, signed weight operand, Q6.9.
- in_bias, input, DATA_W, signed neuron bias, Q6.9; sampled only on the first pair of a vector.
- out_valid, output, 1, out_z holds a finished pre-activation.
- out_ready, input, 1, the downstream stage consumes out_z.
- out_z, output, DATA_W, signed rounded and saturated pre-activation, Q6.9.
- busy, output, 1, a vector is partially accumulated or a result is pending.

Behaviour:
- Clock and reset: one clock domain; rst is asynchronous and active-high.
- Reset values: state=IDLE, count=0, acc=0, out_z=0, out_valid=0, in_ready=1, busy=0. Reset asserted mid-vector or mid-output discards all partial data with no output.
- Handshake: a pair is accepted on a rising edge with in_valid && in_ready. A result is consumed on a rising edge with out_valid && out_ready.
- State IDLE (count=0, in_ready=1):
  - On accept, load acc = sext(x*w) + (sext(in_bias) << FRAC); count=1.
  - If VEC_LEN=1, go to FIN; otherwise go to ACC.
- State ACC (in_ready=1, busy=1):
  - On accept, acc += sext(x*w); count++.
  - On the accept that makes count = VEC_LEN, go to FIN.
  - in_valid low leaves everything unchanged; gaps are unlimited.
- State FIN (in_ready=0, busy=1), one cycle:
  - r = (acc + (1 << (FRAC-1))) >>> FRAC, i.e. round half toward +inf with an arithmetic shift.
  - Saturate r to [-32768, 32767].
  - Register the result into out_z, set out_valid=1, go to OUT.
- State OUT (in_ready=0, out_valid=1, busy=1):
  - out_z and out_valid are stable until consumed.
  - On consume: out_valid=0, count=0, acc=0, go to IDLE.
  - There is no bypass. The next vector's first pair is accepted no earlier than the cycle after consume, giving a minimum of VEC_LEN+2 cycles per neuron.
- Latency: the last pair is accepted at edge N; out_valid rises at edge N+1.
- Arithmetic: product is signed DATA_W x DATA_W into 2*DATA_W bits (Q12.18), sign-extended to ACC_W. ACC_W guarantees the accumulator never wraps, so saturation happens only at the output.
- Ignored inputs: in_x, in_w and in_bias are don't-care when not accepted. in_bias is ignored on pairs 2..VEC_LEN.
- Simultaneous events: out_ready may be held high permanently; in_valid high while in FIN or OUT is stalled without any loss of that pair.

Test Plan:
- Unity sum: 8 pairs x=0x0200, w=0x0200, bias=0x0000, continuous valid, out_ready=1. Required: out_z=0x1000 (8.0) with out_valid high exactly one cycle, rising at edge N+1 after the 8th accept.
- Bias and rounding: bias=0x0100 (0.5); pair0 x=0x0001, w=0x0100; remaining pairs x=0. Required: out_z=0x0101. Repeat with x=0xFFFF. Required: out_z=0x0100 (the half rounds up).
- Saturation: 8 pairs x=0x7FFF, w=0x7FFF. Required: out_z=0x7FFF. Then 8 pairs x=0x7FFF, w=0x8000. Required: out_z=0x8000.
- Backpressure: complete a vector with out_ready=0 for 5 cycles while in_valid stays high with the next vector's data. Required: out_z stable, in_ready=0 throughout, no pair lost. The next vector starts the cycle after consume; both results are correct.
- Bubbles: insert random in_valid gaps of 0–3 cycles; random data is checked against a reference model. Required: 200 vectors with zero mismatches.
- Reset mid-vector: assert rst after 4 accepts, then deassert and send a full unity vector. Required: out_valid=0 during reset; the next out_z=0x1000; busy=0 right after reset.
